// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin time-sharing of one 8x8 unsigned array
// multiplier between requesters A and B, with a req/done handshake.
// The operands are captured at grant and held for MUL_CYCLES clocks
// while the array settles. The product is then registered.

// Unsigned 8x8 array multiplier (shift-add partial products), purely combinational.
module mult_array8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // Sum the gated partial-product rows; each row is 'a' shifted by its bit of 'b'
  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p + ({8'd0, a} << i);
    end
  end
endmodule

module mult_share_ctrl #(
  parameter int MUL_CYCLES = 2  // legal range 1..15
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        ReqA,
  input  logic [7:0]  OpA_X,
  input  logic [7:0]  OpA_Y,
  input  logic        ReqB,
  input  logic [7:0]  OpB_X,
  input  logic [7:0]  OpB_Y,
  output logic        GntA,
  output logic        GntB,
  output logic        DoneA,
  output logic        DoneB,
  output logic [15:0] Result,
  output logic        Busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  // last_q: 0 = A served last, 1 = B served last. While busy it also names
  // the current owner, because it is updated with the winner on the grant edge.
  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  xr_q, xr_d;
  logic [7:0]  yr_q, yr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;

  logic [15:0] prod;
  logic        win_b;

  mult_array8 u_mul (.a(xr_q), .b(yr_q), .p(prod));

  // On a tie, B wins only if A was served last; a lone request always wins
  assign win_b = ReqB & (~ReqA | ~last_q);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    xr_d     = xr_q;
    yr_d     = yr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (ReqA || ReqB) begin
          last_d  = win_b;
          xr_d    = win_b ? OpB_X : OpA_X;
          yr_d    = win_b ? OpB_Y : OpA_Y;
          cnt_d   = 4'(MUL_CYCLES - 1);
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = prod;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset leaves B as last-served so A wins the first tie
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      xr_q     <= '0;
      yr_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      xr_q     <= xr_d;
      yr_q     <= yr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs are decoded only from registered state, so they are glitch-free
  always_comb begin
    Busy   = (state_q != S_IDLE);
    GntA   = Busy & ~last_q;
    GntB   = Busy &  last_q;
    DoneA  = (state_q == S_DONE) & ~last_q;
    DoneB  = (state_q == S_DONE) &  last_q;
    Result = result_q;
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: a vector table of single operations
// plus hand-written sequences for ties, contention, reset and latency limits.
module tb_mult_share_ctrl;

  logic        Clock = 0;
  logic        Resetn = 0;
  logic        ReqA = 0, ReqB = 0;
  logic [7:0]  OpA_X = 0, OpA_Y = 0, OpB_X = 0, OpB_Y = 0;
  logic        GntA, GntB, DoneA, DoneB, Busy;
  logic [15:0] Result;

  // boundary instances, MUL_CYCLES = 1 and 15
  logic        r1_req = 0, r15_req = 0, zero_b = 0;
  logic [7:0]  r1_x = 0, r1_y = 0, r15_x = 0, r15_y = 0, zero8 = 0;
  logic        g1a, g1b, d1a, d1b, b1, g15a, g15b, d15a, d15b, b15;
  logic [15:0] res1, res15;

  int n_tests = 0, n_fail = 0, viol = 0;

  always #5 Clock = ~Clock;

  mult_share_ctrl #(.MUL_CYCLES(2)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .ReqA(ReqA), .OpA_X(OpA_X), .OpA_Y(OpA_Y),
    .ReqB(ReqB), .OpB_X(OpB_X), .OpB_Y(OpB_Y),
    .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
    .Result(Result), .Busy(Busy));

  mult_share_ctrl #(.MUL_CYCLES(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn),
    .ReqA(r1_req), .OpA_X(r1_x), .OpA_Y(r1_y),
    .ReqB(zero_b), .OpB_X(zero8), .OpB_Y(zero8),
    .GntA(g1a), .GntB(g1b), .DoneA(d1a), .DoneB(d1b),
    .Result(res1), .Busy(b1));

  mult_share_ctrl #(.MUL_CYCLES(15)) dut15 (
    .Clock(Clock), .Resetn(Resetn),
    .ReqA(r15_req), .OpA_X(r15_x), .OpA_Y(r15_y),
    .ReqB(zero_b), .OpB_X(zero8), .OpB_Y(zero8),
    .GntA(g15a), .GntB(g15b), .DoneA(d15a), .DoneB(d15b),
    .Result(res15), .Busy(b15));

  // Grant exclusivity and Done-within-Gnt on the main instance, every cycle
  always @(negedge Clock) begin
    if ((GntA && GntB) || (DoneA && !GntA) || (DoneB && !GntB)) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    ReqA = 0; ReqB = 0; r1_req = 0; r15_req = 0;
    @(negedge Clock); Resetn = 0;
    @(negedge Clock); Resetn = 1;
  endtask

  typedef struct {
    logic        side;   // 0 = A, 1 = B
    logic [7:0]  x, y;
    logic [15:0] exp;
  } vec_t;

  // Record of Done pulses observed by watch()
  logic        ev_side [8];
  logic [15:0] ev_res  [8];
  int          ev_cyc  [8];

  // Collect k Done pulses; with drop set, the finished side releases its Req
  task automatic watch(input int k, input bit drop);
    int got = 0, cyc = 0;
    while (got < k && cyc < 200) begin
      @(negedge Clock); cyc++;
      if (DoneA) begin
        ev_side[got] = 0; ev_res[got] = Result; ev_cyc[got] = cyc; got++;
        if (drop) ReqA = 0;
      end else if (DoneB) begin
        ev_side[got] = 1; ev_res[got] = Result; ev_cyc[got] = cyc; got++;
        if (drop) ReqB = 0;
      end
    end
    chk("watch_done_count", got, k);
  endtask

  initial begin
    vec_t vecs [6];
    int n, m, busy_n, other;
    vecs[0] = '{side: 1'b0, x: 8'd12,  y: 8'd10,  exp: 16'd120};
    vecs[1] = '{side: 1'b1, x: 8'd3,   y: 8'd7,   exp: 16'd21};
    vecs[2] = '{side: 1'b0, x: 8'd0,   y: 8'd55,  exp: 16'd0};
    vecs[3] = '{side: 1'b1, x: 8'd255, y: 8'd255, exp: 16'hFE01};
    vecs[4] = '{side: 1'b0, x: 8'h80,  y: 8'h02,  exp: 16'h0100};
    vecs[5] = '{side: 1'b1, x: 8'd255, y: 8'd1,   exp: 16'd255};

    // reset state
    @(negedge Clock);
    chk("rst_gnta", GntA, 0);   chk("rst_gntb", GntB, 0);
    chk("rst_donea", DoneA, 0); chk("rst_doneb", DoneB, 0);
    chk("rst_result", Result, 0); chk("rst_busy", Busy, 0);
    Resetn = 1;

    // single-requester vector table, MUL_CYCLES = 2
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (vecs[i].side) begin ReqB = 1; OpB_X = vecs[i].x; OpB_Y = vecs[i].y; end
      else              begin ReqA = 1; OpA_X = vecs[i].x; OpA_Y = vecs[i].y; end
      n = 0;
      do begin @(negedge Clock); n++; end
      while (!(vecs[i].side ? GntB : GntA) && n < 8);
      chk("vec_grant_lat", n, 1);
      busy_n = Busy; other = 0; m = 0;
      while (!(vecs[i].side ? DoneB : DoneA) && m < 20) begin
        @(negedge Clock); m++;
        busy_n += Busy;
        other += vecs[i].side ? (GntA | DoneA) : (GntB | DoneB);
      end
      chk("vec_done_lat", m, 2);
      chk("vec_result", Result, vecs[i].exp);
      chk("vec_other_side_quiet", other, 0);
      ReqA = 0; ReqB = 0;
      @(negedge Clock);
      chk("vec_busy_cycles", busy_n, 3);
      chk("vec_idle_busy", Busy, 0);
      chk("vec_idle_gnt", {GntA, GntB}, 0);
      chk("vec_result_hold", Result, vecs[i].exp);
    end

    // tie immediately after reset: A first, then B
    do_reset();
    @(negedge Clock);
    ReqA = 1; OpA_X = 255; OpA_Y = 255;
    ReqB = 1; OpB_X = 3;   OpB_Y = 7;
    watch(2, 1);
    chk("tie_first_side", ev_side[0], 0); chk("tie_first_res", ev_res[0], 16'hFE01);
    chk("tie_second_side", ev_side[1], 1); chk("tie_second_res", ev_res[1], 16'd21);

    // continuous contention: A,B,A,B spaced MUL_CYCLES+2 = 4 clocks
    do_reset();
    @(negedge Clock);
    ReqA = 1; OpA_X = 2; OpA_Y = 3;
    ReqB = 1; OpB_X = 4; OpB_Y = 5;
    watch(4, 0);
    ReqA = 0; ReqB = 0;
    for (int i = 0; i < 4; i++) begin
      chk("cont_side", ev_side[i], i % 2);
      chk("cont_res", ev_res[i], (i % 2) ? 16'd20 : 16'd6);
      if (i > 0) chk("cont_spacing", ev_cyc[i] - ev_cyc[i-1], 4);
    end
    repeat (3) @(negedge Clock);

    // operands change and Req drops after grant
    @(negedge Clock);
    ReqA = 1; OpA_X = 9; OpA_Y = 9;
    @(negedge Clock);
    chk("opchg_gnt", GntA, 1);
    OpA_X = 1; OpA_Y = 1;
    @(negedge Clock);
    ReqA = 0;
    m = 0;
    while (!DoneA && m < 10) begin @(negedge Clock); m++; end
    chk("opchg_done_seen", DoneA, 1);
    chk("opchg_result", Result, 16'd81);
    @(negedge Clock);

    // reset in the middle of an operation
    ReqA = 1; OpA_X = 12; OpA_Y = 10;
    @(negedge Clock);
    chk("midrst_gnt_before", GntA, 1);
    @(negedge Clock);
    Resetn = 0;
    #1;
    chk("midrst_async_outs", {GntA, GntB, DoneA, DoneB, Busy}, 0);
    chk("midrst_result", Result, 0);
    @(negedge Clock);
    Resetn = 1; ReqA = 0; ReqB = 1; OpB_X = 3; OpB_Y = 7;
    @(negedge Clock);
    chk("midrst_gntb", {GntA, GntB}, 2'b01);
    chk("midrst_result_not_restored", Result, 0);
    m = 0;
    while (!DoneB && m < 10) begin @(negedge Clock); m++; end
    chk("midrst_doneb_lat", m, 2);
    chk("midrst_b_result", Result, 16'd21);
    ReqB = 0;
    @(negedge Clock);

    // boundary MUL_CYCLES = 1
    r1_req = 1; r1_x = 8'h80; r1_y = 8'h02;
    @(negedge Clock);
    chk("mc1_gnt", g1a, 1);
    m = 0;
    while (!d1a && m < 10) begin @(negedge Clock); m++; end
    chk("mc1_done_lat", m, 1);
    chk("mc1_result", res1, 16'h0100);
    r1_req = 0;

    // boundary MUL_CYCLES = 15
    r15_req = 1; r15_x = 8'hFF; r15_y = 8'h00;
    @(negedge Clock);
    chk("mc15_gnt", g15a, 1);
    m = 0;
    while (!d15a && m < 40) begin @(negedge Clock); m++; end
    chk("mc15_done_lat", m, 15);
    chk("mc15_result", res15, 16'h0000);
    r15_req = 0;
    @(negedge Clock);
    chk("mc15_idle", b15, 0);

    chk("gnt_done_exclusive", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
